ofpga_cfg_readback: RTL and testbench
=====================================

Name: ofpga_cfg_readback

Overview:
Reader side of the fabric configuration path. The config loader writes frames into config memory; this block reads those frames back and serializes them MSB-first onto a bit stream routed to the tt_um_openfpga22 uio pins, then appends a CRC-8. Host software uses it to verify a loaded bitstream without reprogramming. It sits between config memory (a synchronous read port) and the pin mux.

Parameters:
WORD_W, 8, config word width in bits (power of two, 8..32)
ADDR_W, 6, config memory address width
CRC_POLY, 8'h07, CRC-8 polynomial; init 8'h00, no reflection, no final XOR

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ena  in  1  design enable; when low, FSM holds state and all strobes are 0
start  in  1  single-cycle pulse; begins readback when idle
num_words  in  ADDR_W  number of words minus 1 (0 means 1 word), sampled at start
rd_en  out  1  config memory read strobe
rd_addr  out  ADDR_W  config memory read address
rd_data  in  WORD_W  read data, valid exactly 1 cycle after rd_en
sdo  out  1  serial data bit
sdo_valid  out  1  sdo holds a valid bit
sdo_ready  in  1  sink accepts the bit when sdo_valid && sdo_ready
sdo_last  out  1  marks the final CRC bit
busy  out  1  readback in progress
done  out  1  one-cycle pulse after the last bit is accepted
crc  out  8  final CRC; held until next start

Behaviour:
- Reset: state IDLE; rd_en=0, rd_addr=0, sdo=0, sdo_valid=0, sdo_last=0, busy=0, done=0, crc=0. Reset is asynchronous, and a reset mid-readback aborts cleanly with no partial done.
- FSM states: IDLE, FETCH, WAIT, SHIFT, CRC, DONE.
- IDLE: on start && ena, latch num_words, clear addr/crc_acc/bit counter, set busy=1, go to FETCH. start is ignored while busy.
- FETCH: rd_en=1 for exactly one cycle with rd_addr=current addr, then go to WAIT.
- WAIT: capture rd_data into the shift register, then go to SHIFT. Read latency is fixed at 1.
- SHIFT: sdo=shreg[WORD_W-1], sdo_valid=1. sdo holds stable until accepted.
  - On handshake: shift left, update crc_acc with the sent bit, increment the bit counter.
  - After bit WORD_W-1 is accepted: if addr==num_words go to CRC; else addr+1 and go to FETCH.
  - Inter-word bubble is 2 cycles with sdo_valid=0.
- CRC: shift out crc_acc MSB-first, 8 bits, under the same handshake. The CRC bits do not feed crc_acc. sdo_last=1 on the 8th bit.
- DONE: crc output is written from crc_acc, done=1 for one cycle, busy=0, return to IDLE.
- CRC update per bit b: fb = crc_acc[7]^b; crc_acc = {crc_acc[6:0],1'b0} ^ (fb ? CRC_POLY : 0).
- Address arithmetic is ADDR_W wide. num_words = all-ones reads the full space and must not wrap early or loop.
- With sdo_ready held low indefinitely, the block stalls with sdo/sdo_valid stable. No timeout.
- ena low freezes all state. rd_en, sdo_valid and done are forced to 0 while ena=0; on re-enable the block resumes exactly where it stopped.
- Throughput with sdo_ready=1: WORD_W+2 cycles per word, plus 8 CRC cycles and 1 DONE cycle.

Decomposition:
- Package ofpga_cfg_pkg: state enum, CRC_POLY default, CRC_INIT constant, and a function crc8_bit(crc, bit).
- One sub-module is natural: ofpga_crc8_serial, a bitwise CRC accumulator with clr/en/bit inputs and crc output. It is reused by the loader for write-side checking.
- The FSM, address counter and shift register stay in the top.

Test Plan:
- 1 word, mem[0]=8'h01, num_words=0, sdo_ready=1 -> bits 00000001 then CRC 00000111; crc=8'h07; done 1 cycle after the last bit; sdo_last only on the final bit.
- 4 words 01,02,03,04, num_words=3 -> 32 data bits in order, crc=8'hE3; rd_addr sequence 0,1,2,3 with exactly 4 rd_en pulses.
- Random sdo_ready backpressure (about 50% low) on the 4-word case -> identical bit sequence and crc=8'hE3; sdo stays stable while valid && !ready.
- rst_n asserted during word 2, then a new start -> outputs go to reset values immediately; the new run is correct; no done from the aborted run.
- ena deasserted for 10 cycles mid-SHIFT -> no handshakes or rd_en during that time; the resumed stream matches the uninterrupted reference.
- start pulsed while busy, plus ADDR_W=3 with num_words=7 -> second start ignored; exactly 8 words read, addr 7 is the last, no wrap to 0.

Source files
------------

// File: rtl/ofpga_cfg_pkg.sv
// rtl/ofpga_cfg_pkg.sv - shared types, constants and CRC-8 step for config readback
package ofpga_cfg_pkg;

   // Readback sequencer states
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_WAIT  = 3'd2,
      ST_SHIFT = 3'd3,
      ST_CRC   = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

   localparam logic [7:0] CRC_POLY_DEF = 8'h07;
   localparam logic [7:0] CRC_INIT     = 8'h00;

   // One serial CRC-8 step: MSB-first, no reflection, no final XOR
   function automatic logic [7:0] crc8_bit(input logic [7:0] crc,
                                           input logic       b,
                                           input logic [7:0] poly = CRC_POLY_DEF);
      logic fb;
      fb = crc[7] ^ b;
      return {crc[6:0], 1'b0} ^ (fb ? poly : 8'h00);
   endfunction

endpackage

// File: rtl/ofpga_crc8_serial.sv
// rtl/ofpga_crc8_serial.sv - bit-serial CRC-8 accumulator with clear and enable
module ofpga_crc8_serial
   import ofpga_cfg_pkg::*;
#(
   parameter logic [7:0] POLY = CRC_POLY_DEF
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_clr,
   input  logic       i_en,
   input  logic       i_bit,
   output logic [7:0] o_crc
);

   logic [7:0] r_crc;

   // Accumulate one bit per enabled cycle; clear wins over enable
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_crc <= CRC_INIT;
      end else if (i_clr) begin
         r_crc <= CRC_INIT;
      end else if (i_en) begin
         r_crc <= crc8_bit(r_crc, i_bit, POLY);
      end
   end

   assign o_crc = r_crc;

endmodule

// File: rtl/ofpga_cfg_readback.sv
// rtl/ofpga_cfg_readback.sv - reads config frames back and serializes them with a trailing CRC-8
module ofpga_cfg_readback
   import ofpga_cfg_pkg::*;
#(
   parameter int         WORD_W   = 8,
   parameter int         ADDR_W   = 6,
   parameter logic [7:0] CRC_POLY = CRC_POLY_DEF
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_ena,
   input  logic              i_start,
   input  logic [ADDR_W-1:0] i_num_words,
   output logic              o_rd_en,
   output logic [ADDR_W-1:0] o_rd_addr,
   input  logic [WORD_W-1:0] i_rd_data,
   output logic              o_sdo,
   output logic              o_sdo_valid,
   input  logic              i_sdo_ready,
   output logic              o_sdo_last,
   output logic              o_busy,
   output logic              o_done,
   output logic [7:0]        o_crc
);

   localparam int CNT_W = $clog2(WORD_W);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W-1:0] r_num_words;
   logic [WORD_W-1:0] r_shreg;
   logic [CNT_W-1:0]  r_cnt;
   logic [7:0]        r_crc;

   logic [7:0]        w_crc_acc;
   logic              w_hs;
   logic              w_last_data;
   logic              w_last_crc;
   logic              w_addr_end;
   logic              w_crc_clr;
   logic              w_crc_en;
   logic              w_crc_bit;

   // Handshake only exists while enabled, because o_sdo_valid is gated by ena
   assign w_hs        = o_sdo_valid && i_sdo_ready;
   assign w_last_data = (r_cnt == CNT_W'(WORD_W - 1));
   assign w_last_crc  = (r_cnt[2:0] == 3'd7);
   // Compare before incrementing so an all-ones count stops at the top address
   assign w_addr_end  = (r_addr == r_num_words);
   assign w_crc_clr   = i_ena && (r_state == ST_IDLE) && i_start;
   assign w_crc_en    = w_hs && (r_state == ST_SHIFT);
   // CRC phase reads the frozen accumulator MSB-first by bit index
   assign w_crc_bit   = w_crc_acc[3'd7 - r_cnt[2:0]];

   ofpga_crc8_serial #(
      .POLY (CRC_POLY)
   ) u_crc (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_clr   (w_crc_clr),
      .i_en    (w_crc_en),
      .i_bit   (r_shreg[WORD_W-1]),
      .o_crc   (w_crc_acc)
   );

   // State register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and strobe decode; everything holds while ena is low
   always_comb begin
      w_state_nxt = r_state;
      o_rd_en     = 1'b0;
      o_sdo_valid = 1'b0;
      o_sdo_last  = 1'b0;
      o_done      = 1'b0;
      if (i_ena) begin
         case (r_state)
            ST_IDLE: begin
               if (i_start) w_state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
               o_rd_en     = 1'b1;
               w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
               w_state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
               o_sdo_valid = 1'b1;
               if (i_sdo_ready && w_last_data) begin
                  w_state_nxt = w_addr_end ? ST_CRC : ST_FETCH;
               end
            end
            ST_CRC: begin
               o_sdo_valid = 1'b1;
               o_sdo_last  = w_last_crc;
               if (i_sdo_ready && w_last_crc) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
               o_done      = 1'b1;
               w_state_nxt = ST_IDLE;
            end
            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   // Address, word count, shift register, bit counter and result CRC
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_addr      <= '0;
         r_num_words <= '0;
         r_shreg     <= '0;
         r_cnt       <= '0;
         r_crc       <= 8'h00;
      end else if (i_ena) begin
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_num_words <= i_num_words;
                  r_addr      <= '0;
                  r_cnt       <= '0;
               end
            end
            ST_WAIT: begin
               r_shreg <= i_rd_data;
               r_cnt   <= '0;
            end
            ST_SHIFT: begin
               if (w_hs) begin
                  r_shreg <= {r_shreg[WORD_W-2:0], 1'b0};
                  if (w_last_data) begin
                     r_cnt <= '0;
                     if (!w_addr_end) r_addr <= r_addr + 1'b1;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end
            ST_CRC: begin
               if (w_hs) begin
                  if (w_last_crc) begin
                     r_cnt <= '0;
                     r_crc <= w_crc_acc;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign o_rd_addr = r_addr;
   assign o_crc     = r_crc;
   assign o_busy    = (r_state == ST_FETCH) || (r_state == ST_WAIT) ||
                      (r_state == ST_SHIFT) || (r_state == ST_CRC);
   assign o_sdo     = (r_state == ST_SHIFT) ? r_shreg[WORD_W-1] :
                      (r_state == ST_CRC)   ? w_crc_bit : 1'b0;

endmodule

// File: tb/tb_ofpga_cfg_readback.sv
// tb/tb_ofpga_cfg_readback.sv - directed self-checking bench for ofpga_cfg_readback
module tb_ofpga_cfg_readback;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b0;
   logic       start = 1'b0;
   logic [2:0] num_words = 3'd0;
   logic       rd_en;
   logic [2:0] rd_addr;
   logic [7:0] rd_data = 8'h00;
   logic       sdo;
   logic       sdo_valid;
   logic       sdo_ready = 1'b1;
   logic       sdo_last;
   logic       busy;
   logic       done;
   logic [7:0] crc;

   logic [7:0] mem [8];

   int errors = 0;
   int checks = 0;

   logic [127:0] got;
   logic [23:0]  addr_seq;
   int nbits, nrd, ndone, nlast, last_at;
   int first_rd, last_hs, done_cyc;
   int stall_err, pause_err;

   ofpga_cfg_readback #(
      .WORD_W   (8),
      .ADDR_W   (3),
      .CRC_POLY (8'h07)
   ) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_ena       (ena),
      .i_start     (start),
      .i_num_words (num_words),
      .o_rd_en     (rd_en),
      .o_rd_addr   (rd_addr),
      .i_rd_data   (rd_data),
      .o_sdo       (sdo),
      .o_sdo_valid (sdo_valid),
      .i_sdo_ready (sdo_ready),
      .o_sdo_last  (sdo_last),
      .o_busy      (busy),
      .o_done      (done),
      .o_crc       (crc)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rd_en) rd_data <= mem[rd_addr];
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_start(input logic [2:0] nw);
      @(posedge clk); #1;
      num_words = nw;
      start     = 1'b1;
      @(posedge clk); #1;
      start     = 1'b0;
   endtask

   task automatic run(input bit bp, input int pause_at, input int abort_at, input int busy_start_at);
      bit   prev_stall;
      logic prev_sdo;
      bit   paused;
      got = '0; addr_seq = '0;
      nbits = 0; nrd = 0; ndone = 0; nlast = 0; last_at = -1;
      first_rd = -1; last_hs = -1; done_cyc = -1;
      stall_err = 0; pause_err = 0;
      prev_stall = 1'b0; prev_sdo = 1'b0; paused = 1'b0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         @(negedge clk);
         if (!paused && nbits == pause_at && sdo_valid) begin
            paused = 1'b1;
            ena = 1'b0;
            #1;
            if (rd_en || sdo_valid || done) pause_err++;
            repeat (10) begin
               @(negedge clk);
               if (rd_en || sdo_valid || done) pause_err++;
            end
            ena = 1'b1;
            #1;
         end
         if (nbits == abort_at) begin
            rst_n = 1'b0;
            #1;
            chk("abort_reset_outputs",
                128'({rd_en, rd_addr, sdo, sdo_valid, sdo_last, busy, done, crc}), 128'd0);
            repeat (2) @(negedge clk);
            if (done) ndone++;
            rst_n = 1'b1;
            break;
         end
         if (rd_en) begin
            if (nrd == 0) first_rd = cyc;
            nrd++;
            addr_seq = {addr_seq[20:0], rd_addr};
         end
         if (prev_stall && (sdo !== prev_sdo || sdo_valid !== 1'b1)) stall_err++;
         if (sdo_valid && sdo_ready) begin
            got = {got[126:0], sdo};
            nbits++;
            last_hs = cyc;
            if (sdo_last) begin
               nlast++;
               last_at = nbits;
            end
         end
         prev_stall = sdo_valid && !sdo_ready;
         prev_sdo   = sdo;
         if (done) begin
            ndone++;
            done_cyc = cyc;
            break;
         end
         @(posedge clk); #1;
         sdo_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         if (cyc == busy_start_at) begin
            start     = 1'b1;
            num_words = 3'd0;
         end else begin
            start     = 1'b0;
         end
      end
      @(posedge clk); #1;
      sdo_ready = 1'b1;
      start     = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 8; i++) mem[i] = 8'(i + 1);

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs",
          128'({rd_en, rd_addr, sdo, sdo_valid, sdo_last, busy, done, crc}), 128'd0);
      rst_n = 1'b1;
      ena   = 1'b1;

      // single word 0x01 -> data 01, CRC 07
      do_start(3'd0);
      run(1'b0, -1, -1, -1);
      chk("w1_done_count", 128'(ndone), 128'd1);
      chk("w1_stream", {got[15:0], 16'(nbits)}, {16'h0107, 16'd16});
      chk("w1_last_pos", 128'({16'(nlast), 16'(last_at)}), 128'({16'd1, 16'd16}));
      chk("w1_crc", 128'(crc), 128'h07);
      chk("w1_done_after_last", 128'(done_cyc - last_hs), 128'd1);
      chk("w1_latency", 128'(done_cyc - first_rd), 128'd18);
      chk("w1_busy_after", 128'(busy), 128'd0);

      // four words 01..04 -> CRC E3, addresses 0..3
      do_start(3'd3);
      run(1'b0, -1, -1, -1);
      chk("w4_stream", got[39:0], 128'({32'h01020304, 8'hE3}));
      chk("w4_crc", 128'(crc), 128'hE3);
      chk("w4_rd_count", 128'(nrd), 128'd4);
      chk("w4_addr_seq", 128'(addr_seq[11:0]), 128'({3'd0, 3'd1, 3'd2, 3'd3}));
      chk("w4_latency", 128'(done_cyc - first_rd), 128'd48);

      // four words under random backpressure
      do_start(3'd3);
      run(1'b1, -1, -1, -1);
      chk("bp_stream", {got[39:0], 16'(nbits)}, 128'({32'h01020304, 8'hE3, 16'd40}));
      chk("bp_crc", 128'(crc), 128'hE3);
      chk("bp_stable", 128'(stall_err), 128'd0);

      // reset during word 2, then a fresh run
      do_start(3'd3);
      run(1'b0, -1, 12, -1);
      chk("abort_no_done", 128'(ndone), 128'd0);
      do_start(3'd3);
      run(1'b0, -1, -1, -1);
      chk("post_abort_stream", got[39:0], 128'({32'h01020304, 8'hE3}));
      chk("post_abort_done", 128'(ndone), 128'd1);
      chk("post_abort_crc", 128'(crc), 128'hE3);

      // ena low for 10 cycles mid-SHIFT
      do_start(3'd3);
      run(1'b0, 5, -1, -1);
      chk("ena_stream", got[39:0], 128'({32'h01020304, 8'hE3}));
      chk("ena_quiet", 128'(pause_err), 128'd0);
      chk("ena_latency", 128'(done_cyc - first_rd), 128'd48);
      chk("ena_crc", 128'(crc), 128'hE3);

      // full 8-word space with a start pulse while busy
      do_start(3'd7);
      run(1'b0, -1, -1, 20);
      chk("full_rd_count", 128'(nrd), 128'd8);
      chk("full_addr_seq", 128'(addr_seq),
          128'({3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7}));
      chk("full_stream", got[71:0], 128'({64'h0102030405060708, 8'h3E}));
      chk("full_crc", 128'(crc), 128'h3E);
      chk("full_done", 128'(ndone), 128'd1);
      nrd = 0;
      repeat (6) begin
         @(negedge clk);
         if (rd_en || busy) nrd++;
      end
      chk("full_no_loop", 128'(nrd), 128'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
